uart_rx_to_mem: RTL and testbench
=================================

Name: uart_rx_to_mem

Overview:
- Receive-side counterpart of the matrix transmit path.
- Deserialises 8N1 UART bytes from the serial line and writes them row-major into a matrix memory (memory write port: write, write_address, write_value).
- Armed by a load request. After ROW*COLUMN bytes it signals completion, so the multiplier/transmit path can consume the matrix.
- Sits between the board RX pin and the write side of a matrix memory instance.

Parameters:
- ROW, 2, matrix rows.
- COLUMN, 2, matrix columns. ROW*COLUMN must be ≤ 2^ADDR_W.
- ADDR_W, 6, memory address width.
- CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600). Must be ≥ 4.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  one clock; reset is asynchronous and active-low.
- rx_data  in  1  UART serial input, asynchronous, idles high.
- load_req  in  1  level request. A rising edge arms a matrix load.
- write  out  1  memory write strobe, one cycle per byte.
- write_address  out  ADDR_W  memory address for the current write.
- write_value  out  8  received byte.
- busy  out  1  high while armed or writing.
- load_done  out  1  one-cycle pulse after the final byte is written.
- frame_err  out  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset (rst=0, asynchronous) clears all outputs to 0 and all counters to 0. Both FSMs go to IDLE. The rx synchroniser is preset to 1.
- A reset in the middle of a load abandons it. Memory contents already written stay as written. No load_done pulse is issued.
- rx_data passes through a 2-flop synchroniser. load_req passes through a 2-flop synchroniser plus an edge detector (sync2 & ~sync3).
- Receiver FSM (sub-module):
  - R_IDLE: wait for synced rx = 0.
  - R_START: count CLKS_PER_BIT/2 cycles. If rx is still 0, go to R_DATA. If rx is 1, it is a glitch: go back to R_IDLE with no output.
  - R_DATA: sample 8 bits, LSB first, each CLKS_PER_BIT cycles apart at mid-bit.
  - R_STOP: sample after CLKS_PER_BIT cycles. If rx = 1, pulse byte_valid for 1 cycle with the byte. If rx = 0, pulse frame_err for 1 cycle and discard the byte.
  - After R_STOP, return to R_IDLE on the next cycle. Back-to-back frames with no idle gap are accepted.
- Loader FSM:
  - L_IDLE: load_req edge → L_ARMED, clear cnt, busy=1. Bytes received in L_IDLE are dropped and do not write memory. frame_err still pulses.
  - L_ARMED: byte_valid → L_WRITE.
  - L_WRITE (1 cycle): write=1, write_address=cnt, write_value=byte, then cnt ← cnt+1.
    - If cnt+1 == ROW*COLUMN → L_DONE.
    - Otherwise → L_ARMED.
  - L_DONE (1 cycle): load_done=1, busy=0 next cycle → L_IDLE.
- Latency:
  - write is asserted exactly 1 cycle after byte_valid.
  - load_done is asserted exactly 1 cycle after the final write.
- write_address and write_value hold their last value when write=0. Only the write strobe is qualified.
- A load_req edge while busy is ignored; it does not restart the load.
- A frame error while L_ARMED does not advance cnt. The matrix waits for a valid byte.
- cnt width is ADDR_W+1. No wrap occurs inside a load. cnt resets to 0 on each new arm.

Decomposition:
- Shared package: UART frame constants (DATA_BITS=8, START=0, STOP=1), receiver state encoding, loader state encoding.
- Sub-module uart_rx_core (synchroniser + receiver FSM), with outputs byte_valid, byte_out[7:0], frame_err.
- Top level holds the loader FSM, the load_req edge detector and the address counter.

Test Plan:
- Use CLKS_PER_BIT=16, ROW=COLUMN=2 in simulation.
- Basic load: load_req 0→1, then send bytes 0x11, 0x22, 0x33, 0x44 → four write pulses at addresses 0, 1, 2, 3 with those values, one load_done pulse, busy drops.
- Idle drop: send 0xA5 with no load_req → no write, no load_done, busy=0.
- Framing error: armed, send 0x5A with stop bit=0 → frame_err pulse, no write. Then send 0x01, 0x02, 0x03, 0x04 → writes at addresses 0–3 with those values.
- Start glitch: rx low for 4 cycles while armed → no byte, no frame_err, cnt unchanged.
- Mid-load reset: armed, 2 bytes written, assert rst=0 for 3 cycles → all outputs 0. Re-arm and send 4 bytes → writes start again at address 0.
- Re-arm while busy: second load_req edge after byte 1 → ignored. Bytes 2–4 go to addresses 1–3, with a single load_done.

Source files
------------

// File: rtl/uart_rx_to_mem_pkg.sv
// Shared definitions for the UART-to-matrix-memory loader: frame constants
// and the state encodings of the receiver and loader FSMs.
package uart_rx_to_mem_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    L_IDLE,
    L_ARMED,
    L_WRITE,
    L_DONE
  } ld_state_e;

endpackage

// File: rtl/uart_rx_to_mem_uart_rx_core.sv
// 8N1 UART receiver: 2-flop rx synchroniser, mid-bit sampling, one-cycle
// byte_valid / frame_err pulses once the stop bit has been sampled.
module uart_rx_core
  import uart_rx_to_mem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       frame_err
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  logic            rx_meta_q, rx_sync_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  // Synchroniser presets to the idle (mark) level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= R_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_data;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      R_IDLE: begin
        clk_cnt_d = '0;
        if (rx_sync_q == START_BIT) state_d = R_START;
      end
      R_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = (rx_sync_q == START_BIT) ? R_DATA : R_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          // LSB arrives first, so shifting in from the top leaves it at bit 0.
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == IDX_LAST) state_d = R_STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = R_IDLE;
          if (rx_sync_q == STOP_BIT) valid_d = 1'b1;
          else ferr_d = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_out   = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_rx_to_mem.sv
// Loads a ROW x COLUMN byte matrix from the UART into memory, row-major,
// after a rising edge on load_req; pulses load_done after the last write.
module uart_rx_to_mem
  import uart_rx_to_mem_pkg::*;
#(
  parameter int ROW          = 2,
  parameter int COLUMN       = 2,
  parameter int ADDR_W       = 6,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data,
  input  logic              load_req,
  output logic              write,
  output logic [ADDR_W-1:0] write_address,
  output logic [7:0]        write_value,
  output logic              busy,
  output logic              load_done,
  output logic              frame_err
);

  localparam int               CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROW * COLUMN);

  logic             byte_valid;
  logic [7:0]       byte_out;

  logic             ld_meta_q, ld_sync_q, ld_prev_q;
  logic             arm_edge;
  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]       value_q, value_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .frame_err  (frame_err)
  );

  assign arm_edge = ld_sync_q & ~ld_prev_q;
  assign cnt_inc  = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_meta_q <= 1'b0;
      ld_sync_q <= 1'b0;
      ld_prev_q <= 1'b0;
      state_q   <= L_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      value_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ld_meta_q <= load_req;
      ld_sync_q <= ld_meta_q;
      ld_prev_q <= ld_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      value_q   <= value_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Address and value are registered alongside the strobe so they hold between writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = 1'b0;
    addr_d  = addr_q;
    value_d = value_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      L_IDLE: begin
        if (arm_edge) begin
          state_d = L_ARMED;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      L_ARMED: begin
        if (byte_valid) begin
          write_d = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          value_d = byte_out;
          state_d = L_WRITE;
        end
      end
      L_WRITE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == LAST_CNT) begin
          done_d  = 1'b1;
          state_d = L_DONE;
        end else begin
          state_d = L_ARMED;
        end
      end
      L_DONE: begin
        busy_d  = 1'b0;
        state_d = L_IDLE;
      end
      default: state_d = L_IDLE;
    endcase
  end

  assign write         = write_q;
  assign write_address = addr_q;
  assign write_value   = value_q;
  assign busy          = busy_q;
  assign load_done     = done_q;

endmodule

// File: tb/tb_uart_rx_to_mem.sv
// Self-checking bench for uart_rx_to_mem: serial frames driven from tasks,
// a matrix-load model fills an expected-write queue, a monitor pops it.
module tb_uart_rx_to_mem;

  localparam int ROW    = 2;
  localparam int COLUMN = 2;
  localparam int ADDR_W = 6;
  localparam int CPB    = 16;
  localparam int TOTAL  = ROW * COLUMN;

  logic              clk;
  logic              rst;
  logic              rx_data;
  logic              load_req;
  logic              write;
  logic [ADDR_W-1:0] write_address;
  logic [7:0]        write_value;
  logic              busy;
  logic              load_done;
  logic              frame_err;

  uart_rx_to_mem #(
    .ROW(ROW), .COLUMN(COLUMN), .ADDR_W(ADDR_W), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .load_req      (load_req),
    .write         (write),
    .write_address (write_address),
    .write_value   (write_value),
    .busy          (busy),
    .load_done     (load_done),
    .frame_err     (frame_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- model + scoreboard state ----------------
  // Entry: {last_of_load, address, value}
  logic [ADDR_W+8:0] exp_q[$];
  bit  m_armed;
  int  m_cnt;
  int  exp_done, exp_ferr, seen_done, seen_ferr;
  int  errors, checks;
  bit  pending_done;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic arm();
    if (!m_armed) begin
      m_armed = 1'b1;
      m_cnt   = 0;
    end
    load_req = 1'b1;
    tick(6);
    load_req = 1'b0;
    tick(4);
    check("busy_after_arm", 32'(busy), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
    if (stop_ok) begin
      if (m_armed) begin
        exp_q.push_back({(m_cnt == TOTAL - 1), ADDR_W'(m_cnt), b});
        m_cnt++;
        if (m_cnt == TOTAL) begin
          m_armed = 1'b0;
          exp_done++;
        end
      end
    end else begin
      exp_ferr++;
    end
    rx_data = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_data = b[i];
      tick(CPB);
    end
    if (stop_ok) begin
      rx_data = 1'b1;
      tick(CPB);
    end else begin
      // Short low stop bit, then a full idle bit so the line settles before the next frame.
      rx_data = 1'b0;
      tick(CPB / 2 + 2);
      rx_data = 1'b1;
      tick(CPB);
    end
    tick(gap);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_write"}, 32'(write), 32'd0);
    check({tag, "_addr"}, 32'(write_address), 32'd0);
    check({tag, "_value"}, 32'(write_value), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [ADDR_W+8:0] e;
    if (pending_done) begin
      checks++;
      if (load_done !== 1'b1) begin
        errors++;
        $display("FAIL done_latency: load_done=%0b expected 1 one cycle after last write", load_done);
      end
    end else if (load_done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: load_done=1 expected 0");
    end
    pending_done = 1'b0;
    if (load_done === 1'b1) seen_done++;
    if (frame_err === 1'b1) seen_ferr++;
    if (write === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d value=%02h with nothing expected",
                 write_address, write_value);
      end else begin
        e = exp_q.pop_front();
        if ({write_address, write_value} !== e[ADDR_W+7:0]) begin
          errors++;
          $display("FAIL write_data: got addr=%0d value=%02h expected addr=%0d value=%02h",
                   write_address, write_value, e[ADDR_W+7:8], e[7:0]);
        end
        pending_done = e[ADDR_W+8];
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    rst      = 1'b0;
    rx_data  = 1'b1;
    load_req = 1'b0;
    m_armed  = 1'b0;
    m_cnt    = 0;
    tick(3);
    check_all_zero("reset");
    rst = 1'b1;
    tick(5);

    // Basic load
    arm();
    send_frame(8'h11, 1'b1, 2);
    send_frame(8'h22, 1'b1, 2);
    send_frame(8'h33, 1'b1, 2);
    send_frame(8'h44, 1'b1, 2);
    tick(8);
    check("basic_busy_low", 32'(busy), 32'd0);
    check("basic_done_count", 32'(seen_done), 32'(exp_done));
    check("basic_queue_empty", 32'(exp_q.size()), 32'd0);

    // Byte while idle is dropped
    send_frame(8'hA5, 1'b1, 8);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done_count", 32'(seen_done), 32'(exp_done));

    // Framing error while armed, then a full load
    arm();
    send_frame(8'h5A, 1'b0, 0);
    check("ferr_count", 32'(seen_ferr), 32'(exp_ferr));
    check("ferr_still_busy", 32'(busy), 32'd1);
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h02, 1'b1, 0);
    send_frame(8'h03, 1'b1, 0);
    send_frame(8'h04, 1'b1, 0);
    tick(8);
    check("ferr_load_done_count", 32'(seen_done), 32'(exp_done));
    check("ferr_load_busy_low", 32'(busy), 32'd0);

    // Start glitch mid-load must not disturb the address sequence
    arm();
    send_frame(8'hC3, 1'b1, 4);
    rx_data = 1'b0;
    tick(4);
    rx_data = 1'b1;
    tick(2 * CPB);
    check("glitch_no_ferr", 32'(seen_ferr), 32'(exp_ferr));
    check("glitch_queue", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1, 1);
    tick(8);
    check("glitch_done_count", 32'(seen_done), 32'(exp_done));

    // Reset in the middle of a load
    arm();
    send_frame(8'h77, 1'b1, 0);
    send_frame(8'h88, 1'b1, 0);
    tick(8);
    check("midreset_two_written", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    tick(1);
    check_all_zero("midreset");
    tick(2);
    rst = 1'b1;
    m_armed = 1'b0;
    m_cnt   = 0;
    tick(5);
    check("midreset_busy_after", 32'(busy), 32'd0);
    arm();
    for (int i = 0; i < TOTAL; i++) send_frame(8'($urandom), 1'b1, 2);
    tick(8);
    check("midreset_done_count", 32'(seen_done), 32'(exp_done));

    // Re-arm while busy is ignored
    arm();
    send_frame(8'hE1, 1'b1, 2);
    arm();
    send_frame(8'hE2, 1'b1, 2);
    send_frame(8'hE3, 1'b1, 2);
    send_frame(8'hE4, 1'b1, 2);
    tick(8);
    check("rearm_done_count", 32'(seen_done), 32'(exp_done));
    check("rearm_busy_low", 32'(busy), 32'd0);

    // Randomised loads with idle traffic, bad frames and varied gaps
    for (int l = 0; l < 6; l++) begin
      if ($urandom_range(0, 2) == 0) send_frame(8'($urandom), 1'b1, 3);
      arm();
      for (int i = 0; i < TOTAL; i++) begin
        if ($urandom_range(0, 5) == 0) send_frame(8'($urandom), 1'b0, 0);
        b = 8'($urandom);
        send_frame(b, 1'b1, $urandom_range(0, 3));
      end
      tick(8);
      check("rand_done_count", 32'(seen_done), 32'(exp_done));
      check("rand_busy_low", 32'(busy), 32'd0);
    end

    tick(20);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_done_count", 32'(seen_done), 32'(exp_done));
    check("final_ferr_count", 32'(seen_ferr), 32'(exp_ferr));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
